mips_cpu_fetch: RTL

//  Instruction-fetch stage directly upstream of the control decoder. Holds the PC and reads one word per

---
 rtl/mips_cpu_pkg.sv | 22 ++
 rtl/mips_cpu_pc_next.sv | 31 +++
 rtl/mips_cpu_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS fetch stage and control decoder.
// PC-select encoding, fetch FSM states and default vectors.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h00000000;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } ctrl_pc_t;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_EXEC      = 2'd2,
    S_HALTED    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/mips_cpu_pc_next.sv
// Branch/jump target computation for the fetch stage.
// Purely combinational: pc, instr fields, rs -> target.
module mips_cpu_pc_next
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  ctrl_pc_t    ctrl_pc_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o
);

  logic [31:0] br_off;

  assign pc_plus4_o = pc_i + 32'd4;
  assign br_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  // Select the control-transfer target for the current instruction
  always_comb begin
    target_o = pc_plus4_o;
    unique case (ctrl_pc_i)
      PC_INC:    target_o = pc_plus4_o;
      PC_BRANCH: target_o = pc_plus4_o + br_off;
      PC_JUMP:   target_o = {pc_plus4_o[31:28], instr_i, 2'b00};
      PC_JREG:   target_o = rs_data_i;
      default:   target_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/mips_cpu_fetch.sv
// MIPS instruction fetch stage with branch delay slot.
// Fetches over an Avalon-style bus and halts on HALT_ADDR.
module mips_cpu_fetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  input  logic [1:0]  ctrl_pc,
  input  logic [31:0] rs_data,
  input  logic        exec_done,
  output logic        active
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         dly_pend_q, dly_pend_d;
  logic [31:0]  dly_tgt_q, dly_tgt_d;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  ctrl_pc_t     sel;

  assign sel = ctrl_pc_t'(ctrl_pc);

  mips_cpu_pc_next u_pc_next (
    .pc_i       (pc_q),
    .instr_i    (instr_q[25:0]),
    .rs_data_i  (rs_data),
    .ctrl_pc_i  (sel),
    .pc_plus4_o (pc_plus4),
    .target_o   (target)
  );

  assign mem_address    = {pc_q[31:2], 2'b00};
  assign mem_byteenable = 4'b1111;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus8       = pc_q + 32'd8;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      dly_pend_q <= 1'b0;
      dly_tgt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      dly_pend_q <= dly_pend_d;
      dly_tgt_q  <= dly_tgt_d;
    end
  end

  // Next-state, next-PC and bus/handshake outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    dly_pend_d  = dly_pend_q;
    dly_tgt_d   = dly_tgt_q;
    next_pc     = pc_plus4;
    mem_read    = 1'b0;
    instr_valid = 1'b0;
    active      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        active   = 1'b1;
        mem_read = 1'b1;
        if (!mem_waitrequest) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        active  = 1'b1;
        instr_d = mem_readdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        active      = 1'b1;
        instr_valid = 1'b1;
        if (exec_done) begin
          if (dly_pend_q) begin
            next_pc    = dly_tgt_q;
            dly_pend_d = 1'b0;
          end else if (sel != PC_INC) begin
            next_pc    = pc_plus4;
            dly_tgt_d  = target;
            dly_pend_d = 1'b1;
          end else begin
            next_pc = pc_plus4;
          end
          pc_d = next_pc;
          if (next_pc == HALT_ADDR || next_pc[1:0] != 2'b00)
            state_d = S_HALTED;
          else
            state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_HALTED;
    endcase
    if (reset) begin
      mem_read    = 1'b0;
      instr_valid = 1'b0;
      active      = 1'b0;
    end
  end

endmodule
